// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Covers the init-sweep state encoding and the preset register addresses and values.
package regfile_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } init_state_e;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ADDR_W    = 6;
   localparam int DEF_NUM_RD    = 2;

   localparam int REG_BASE_ADDR = 0;
   localparam int REG_NM1       = 1;
   localparam int DEF_INIT_R0   = 2;
   localparam int DEF_INIT_R1   = 3;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset initialisation sequencer: walks every address once, supplying the preset value.
// It then parks in READY until the next reset.
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int                 DATA_W  = DEF_DATA_W,
   parameter int                 ADDR_W  = DEF_ADDR_W,
   parameter logic [DATA_W-1:0]  INIT_R0 = DATA_W'(DEF_INIT_R0),
   parameter logic [DATA_W-1:0]  INIT_R1 = DATA_W'(DEF_INIT_R1)
)
(
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_we_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic [DATA_W-1:0] init_data_o,
   output logic              ready_o
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   init_state_e       state_q;
   logic [ADDR_W:0]   cnt_q;
   logic              ready_q;
   logic [DATA_W-1:0] init_data_s;

   // Sweep FSM: one register per cycle, ready rises on the edge that writes the last one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
               end else begin
                  state_q <= ST_INIT;
                  ready_q <= 1'b0;
               end
            end
            ST_READY: begin
               state_q <= ST_READY;
               cnt_q   <= cnt_q;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_INIT;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Preset value for the register currently addressed by the sweep
   always_comb begin
      init_data_s = '0;
      if (cnt_q[ADDR_W-1:0] == ADDR_W'(REG_BASE_ADDR)) begin
         init_data_s = INIT_R0;
      end else if (cnt_q[ADDR_W-1:0] == ADDR_W'(REG_NM1)) begin
         init_data_s = INIT_R1;
      end else begin
         init_data_s = '0;
      end
   end

   assign init_we_o   = (state_q == ST_INIT);
   assign init_addr_o = cnt_q[ADDR_W-1:0];
   assign init_data_o = init_data_s;
   assign ready_o     = ready_q;

endmodule

// File: rtl/regfile_param.sv
// General-purpose register file: one write port and NUM_RD registered read ports with write-first bypass.
// Storage is self-initialised by regfile_init_seq after every reset.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int                 DATA_W  = DEF_DATA_W,
   parameter int                 ADDR_W  = DEF_ADDR_W,
   parameter int                 NUM_RD  = DEF_NUM_RD,
   parameter logic [DATA_W-1:0]  INIT_R0 = DATA_W'(DEF_INIT_R0),
   parameter logic [DATA_W-1:0]  INIT_R1 = DATA_W'(DEF_INIT_R1)
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     ready,
   output logic                     wr_drop
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              init_we_s;
   logic [ADDR_W-1:0] init_addr_s;
   logic [DATA_W-1:0] init_data_s;
   logic              ready_s;
   logic              port_we_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              wr_drop_q;

   regfile_init_seq #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .INIT_R0 (INIT_R0),
      .INIT_R1 (INIT_R1)
   ) u_init_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .init_we_o   (init_we_s),
      .init_addr_o (init_addr_s),
      .init_data_o (init_data_s),
      .ready_o     (ready_s)
   );

   assign port_we_s = wr_en & ready_s;

   // Write mux: the sweep owns the array until ready, then the write port does
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = '0;
      mem_wdata_s = '0;
      if (init_we_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = init_addr_s;
         mem_wdata_s = init_data_s;
      end else if (port_we_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = wr_addr;
         mem_wdata_s = wr_data;
      end else begin
         mem_we_s    = 1'b0;
         mem_waddr_s = '0;
         mem_wdata_s = '0;
      end
   end

   // Storage array, deliberately without reset: the sweep rewrites every entry
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr_s;
      logic [DATA_W-1:0] rd_q;

      assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

      // Registered read; a same-edge write to the addressed register wins over the array
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q <= '0;
         end else if (!ready_s) begin
            rd_q <= '0;
         end else if (wr_en && (wr_addr == addr_s)) begin
            rd_q <= wr_data;
         end else begin
            rd_q <= mem_q[addr_s];
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rd_q;
   end

   // Flag writes that arrive before the sweep has finished
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= wr_en & ~ready_s;
      end
   end

   assign ready   = ready_s;
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized traffic.
// A behavioural register-file model is compared against the DUT every cycle.
module tb_regfile_param;

   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int NR    = 2;
   localparam int DEPTH = 64;

   logic                clk     = 1'b0;
   logic                rst_n   = 1'b1;
   logic                wr_en   = 1'b0;
   logic [AW-1:0]       wr_addr = '0;
   logic [DW-1:0]       wr_data = '0;
   logic [NR*AW-1:0]    rd_addr = '0;
   logic [NR*DW-1:0]    rd_data;
   logic                ready;
   logic                wr_drop;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   regfile_param #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .NUM_RD  (NR),
      .INIT_R0 (32'd2),
      .INIT_R1 (32'd3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .ready   (ready),
      .wr_drop (wr_drop)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: sweep of DEPTH cycles, then a plain array with write-first reads
   logic [DW-1:0]    m_mem [DEPTH];
   int               m_swept;
   bit               m_ready;
   logic [NR*DW-1:0] m_rd;
   bit               m_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_swept <= 0;
         m_ready <= 1'b0;
         m_rd    <= '0;
         m_drop  <= 1'b0;
      end else if (!m_ready) begin
         m_mem[m_swept] <= (m_swept == 0) ? 32'd2 : (m_swept == 1) ? 32'd3 : 32'd0;
         m_swept        <= m_swept + 1;
         m_ready        <= (m_swept + 1 == DEPTH);
         m_rd           <= '0;
         m_drop         <= wr_en;
      end else begin
         for (int k = 0; k < NR; k++) begin
            m_rd[k*DW +: DW] <= (wr_en && wr_addr == rd_addr[k*AW +: AW])
                                ? wr_data : m_mem[rd_addr[k*AW +: AW]];
         end
         if (wr_en) m_mem[wr_addr] <= wr_data;
         m_drop <= 1'b0;
      end
   end

   // Cycle-by-cycle comparison away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("ready", {127'd0, ready}, {127'd0, m_ready});
         chk("wr_drop", {127'd0, wr_drop}, {127'd0, m_drop});
         chk("rd_data", {64'd0, rd_data}, {64'd0, m_rd});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr[0*AW +: AW] = AW'(a0);
      rd_addr[1*AW +: AW] = AW'(a1);
   endtask

   task automatic wait_ready(input string nm, input bit do_drop);
      int n;
      n = 0;
      while (!ready && n < 200) begin
         step();
         n++;
         if (do_drop && n == 3) begin
            wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h0000_DEAD;
         end
         if (do_drop && n == 4) begin
            chk("wr_drop_pulse", {127'd0, wr_drop}, 128'd1);
            wr_en = 1'b0;
         end
         if (do_drop && n == 5) chk("wr_drop_clear", {127'd0, wr_drop}, 128'd0);
      end
      chk(nm, 128'(n), 128'd64);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 chk_on = 1'b1;
      step();
      step();
      chk("reset_ready", {127'd0, ready}, 128'd0);
      chk("reset_rd", {64'd0, rd_data}, 128'd0);
      rst_n = 1'b1;
      wait_ready("ready_latency", 1'b1);

      set_rd(0, 1);
      step();
      chk("r0_init", {96'd0, rd_data[DW-1:0]}, 128'd2);
      chk("r1_init", {96'd0, rd_data[2*DW-1:DW]}, 128'd3);
      set_rd(63, 5);
      step();
      chk("r63_init", {96'd0, rd_data[DW-1:0]}, 128'd0);
      chk("r5_after_drop", {96'd0, rd_data[2*DW-1:DW]}, 128'd0);

      wr_en = 1'b1; wr_addr = AW'(10); wr_data = 32'h1234_5678;
      step();
      wr_en = 1'b0;
      set_rd(10, 63);
      step();
      chk("r10_written", {96'd0, rd_data[DW-1:0]}, 128'h1234_5678);
      chk("r63_untouched", {96'd0, rd_data[2*DW-1:DW]}, 128'd0);

      wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'hA5A5_A5A5;
      set_rd(7, 7);
      step();
      wr_en = 1'b0;
      chk("bypass_p0", {96'd0, rd_data[DW-1:0]}, 128'hA5A5_A5A5);
      chk("bypass_p1", {96'd0, rd_data[2*DW-1:DW]}, 128'hA5A5_A5A5);

      set_rd(1, 0);
      for (int i = 1; i <= 3; i++) begin
         wr_en = 1'b1; wr_addr = AW'(1); wr_data = DW'(i);
         step();
         chk("b2b_r1", {96'd0, rd_data[DW-1:0]}, 128'(i));
      end
      wr_en = 1'b0;

      wr_en = 1'b1; wr_addr = AW'(0); wr_data = 32'hFFFF_0000;
      step();
      wr_en = 1'b0;

      for (int c = 0; c < 1500; c++) begin
         wr_en   = ($urandom_range(0, 2) != 0);
         wr_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wr_data = $urandom;
         rd_addr[0*AW +: AW] = AW'($urandom_range(0, 7));
         rd_addr[1*AW +: AW] = AW'($urandom);
         step();
      end
      wr_en = 1'b0;

      set_rd(7, 7);
      wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h5A5A_0001;
      step();
      wr_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", {127'd0, ready}, 128'd0);
      chk("async_rst_rd", {64'd0, rd_data}, 128'd0);
      #1 rst_n = 1'b1;

      for (int c = 0; c < 30; c++) step();
      #1 rst_n = 1'b0;
      #1;
      chk("midsweep_rst_ready", {127'd0, ready}, 128'd0);
      chk("midsweep_rst_rd", {64'd0, rd_data}, 128'd0);
      #1 rst_n = 1'b1;
      wait_ready("ready_latency_rerun", 1'b0);

      set_rd(0, 1);
      step();
      chk("r0_reinit", {96'd0, rd_data[DW-1:0]}, 128'd2);
      chk("r1_reinit", {96'd0, rd_data[2*DW-1:DW]}, 128'd3);
      step();

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
